// File: rtl/multi_dataflow_engine_fsm.sv
// Job sequencer for the multi_dataflow kernel adapter. It issues load/store
// streamer requests, starts the kernel, and counts per-output done pulses
// against the programmed length. It closes the job with a done/event pulse
// once the kernel reports idle.
module multi_dataflow_engine_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             clear_i,
  input  logic             job_start_i,
  input  logic [CNT_W-1:0] reg_len_i,
  output logic             in_req_valid_o,
  input  logic             in_req_ready_i,
  output logic             out_req_valid_o,
  input  logic             out_req_ready_i,
  output logic             kernel_start_o,
  input  logic             kernel_done_i,
  input  logic             kernel_idle_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             evt_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    COMPUTE,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_valid_q;
  logic             out_valid_q;
  logic             start_q;
  logic             done_q;
  logic             in_ok;
  logic             out_ok;
  logic             unused_test_mode;

  // Test mode has no functional effect on the sequencer.
  assign unused_test_mode = test_mode_i;

  // A request side is finished once its valid has dropped or is being accepted now.
  assign in_ok   = ~in_valid_q  | in_req_ready_i;
  assign out_ok  = ~out_valid_q | out_req_ready_i;
  assign cnt_inc = out_cnt_q + CNT_W'(1);

  // Job sequencing FSM with registered request, start and done outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= '0;
      out_cnt_q   <= '0;
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      out_cnt_q   <= '0;
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_start_i) begin
            len_q     <= reg_len_i;
            out_cnt_q <= '0;
            state_q   <= REQ;
            // A zero-length job passes through REQ without raising requests.
            in_valid_q  <= (reg_len_i != '0);
            out_valid_q <= (reg_len_i != '0);
          end
        end
        REQ: begin
          if (len_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (in_ok && out_ok) begin
            in_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            start_q     <= 1'b1;
            state_q     <= START;
          end else begin
            in_valid_q  <= in_valid_q  & ~in_req_ready_i;
            out_valid_q <= out_valid_q & ~out_req_ready_i;
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= COMPUTE;
        end
        COMPUTE: begin
          // Length is non-zero here, so the counter stops exactly at len_q.
          if (kernel_done_i) begin
            out_cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (kernel_idle_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_req_valid_o  = in_valid_q;
  assign out_req_valid_o = out_valid_q;
  assign kernel_start_o  = start_q;
  assign done_o          = done_q;
  assign evt_o           = done_q;
  assign out_cnt_o       = out_cnt_q;
  assign busy_o          = (state_q != IDLE);

endmodule
